ps2_cmd_sequencer: RTL and testbench
====================================

// Module: ps2_cmd_sequencer
// PURPOSE
//  Host-side command sequencer that sits between system logic and the PS2 host TX/RX core.
//  Runs the power-up keyboard init: reset command 0xFF, then ACK 0xFA, then BAT 0xAA.
//  Executes user commands with an optional argument byte (e.g. 0xED+LEDs), with resend and retry handling.
//  Forwards unsolicited RX bytes (scan codes) to the key stream only while idle.
// PARAMETERS
//  AUTO_INIT    1        1: run the 0xFF init sequence after reset; 0: start in IDLE.
//  TIMEOUT_CYC  2000000  clk cycles to wait for a device reply before declaring timeout.
//  MAX_RETRY    3        resends allowed per byte after a 0xFE/error before NAK.
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  cmd_valid      in   1  user command request
//  cmd_ready      out  1  high in IDLE only; the command is accepted on cmd_valid&cmd_ready
//  cmd_byte       in   8  command byte
//  cmd_has_arg    in   1  the command is followed by arg_byte
//  arg_byte       in   8  argument byte, captured at accept
//  cmd_done       out  1  1-cycle pulse when the command (or init) completes
//  cmd_status     out  2  00 OK, 01 NAK (retries exhausted), 10 timeout, 11 BAT fail; valid with cmd_done
//  init_done      out  1  sticky; set when the init sequence ends OK (tied 1 after reset if AUTO_INIT=0)
//  key_valid      out  1  1-cycle pulse, forwarded RX byte
//  key_data       out  8  forwarded byte
//  key_err        out  1  1-cycle pulse, RX parity/frame error while idle
//  ps2_tx_req     out  1  1-cycle pulse to the PS2 core: send ps2_tx_data
//  ps2_tx_data    out  8  byte to send; held stable from the req until tx_done/tx_err
//  ps2_tx_busy    in   1  PS2 core transmit in progress
//  ps2_tx_done    in   1  pulse; the device line-ACK was seen
//  ps2_tx_err     in   1  pulse; the frame failed (no line ACK)
//  ps2_rx_valid   in   1  pulse; ps2_rx_data is valid
//  ps2_rx_data    in   8  received byte
//  ps2_rx_err     in   1  pulse; received frame has a parity/stop error
// BEHAVIOUR
//  Reset (async): state=INIT_SEND if AUTO_INIT else IDLE.
//   - All outputs 0 except init_done = !AUTO_INIT.
//   - Retry counter, timeout counter and captured bytes are cleared.
//   - A reset mid-transfer abandons it with no cmd_done.
//  States: IDLE, SEND(byte), WAIT_TX, WAIT_ACK, WAIT_BAT, DONE.
//   - The current byte is 0xFF during init, cmd_byte, then arg_byte.
//  SEND: issue ps2_tx_req on the first cycle with ps2_tx_busy=0, then go to WAIT_TX.
//  WAIT_TX:
//   - tx_done: go to WAIT_ACK and clear the timeout counter.
//   - tx_err: counts as a retry and returns to SEND.
//  WAIT_ACK, on rx_valid:
//   - 0xFA: if an argument is pending, SEND arg with retries cleared.
//   - 0xFA, byte was 0xFF (init or user): go to WAIT_BAT.
//   - 0xFA otherwise: go to DONE with status 00.
//   - 0xFE, any other byte, or rx_err: retry++ and resend the same byte.
//  Retries: when retry exceeds MAX_RETRY, go to DONE with status 01 (MAX_RETRY+1 total sends).
//  WAIT_BAT, on rx_valid:
//   - 0xAA: status 00.
//   - Any other byte (e.g. 0xFC) or rx_err: status 11.
//  Timeout: in WAIT_ACK or WAIT_BAT, the counter reaches TIMEOUT_CYC -> status 10.
//   - The counter restarts on every entry into WAIT_ACK or WAIT_BAT; it is $clog2(TIMEOUT_CYC+1) bits.
//   - WAIT_TX has no timeout; the PS2 core guarantees done/err.
//  DONE: cmd_done pulses for 1 cycle, then IDLE.
//   - During init, init_done is set only on status 00; init does not restart on failure.
//  IDLE: cmd_ready=1.
//   - rx_valid: key_valid=1 and key_data=rx byte on the next cycle (latency 1).
//   - rx_err: key_err on the next cycle.
//  RX outside IDLE is consumed by the sequencer and never forwarded.
//  Simultaneous rx_valid and command accept in IDLE: the byte is forwarded and the command starts.
//  Bytes arriving in SEND/WAIT_TX/DONE are dropped.
// TESTING
//  1 AUTO_INIT=1: release reset -> tx_req with 0xFF; model replies FA, then AA -> cmd_done, status 00, init_done=1, no key_valid.
//  2 cmd ED, arg 07; replies FA, FA -> tx bytes ED then 07, status 00.
//  3 cmd F4, replies FE, FE, FA -> three tx_req with F4, status 00. Replies FE x4 (MAX_RETRY=3) -> 4 sends, status 01.
//  4 TIMEOUT_CYC=100, no reply after tx_done -> cmd_done 100 cycles after tx_done, status 10. Init with BAT 0xFC -> status 11, init_done=0.
//  5 IDLE rx 1C -> key_valid with 1C one cycle later. FA during WAIT_ACK is not forwarded. Rx 1C with a same-cycle cmd accept -> both happen.
//  6 Assert reset during WAIT_ACK -> outputs 0 immediately, no cmd_done. After release, IDLE or INIT per AUTO_INIT.

Source files
------------

// File: rtl/ps2_cmd_sequencer_if.sv
// Bundle of the user command/key stream signals and the PS2 core TX/RX handshake.
// The slave modport is the sequencer's view; master is the view of the surrounding logic.
interface ps2_cmd_sequencer_if;
    // user command side
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] arg_byte;
    logic       cmd_done;
    logic [1:0] cmd_status;
    logic       init_done;
    // forwarded key stream
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_err;
    // PS2 host core
    logic       ps2_tx_req;
    logic [7:0] ps2_tx_data;
    logic       ps2_tx_busy;
    logic       ps2_tx_done;
    logic       ps2_tx_err;
    logic       ps2_rx_valid;
    logic [7:0] ps2_rx_data;
    logic       ps2_rx_err;

    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, arg_byte,
        input  ps2_tx_busy, ps2_tx_done, ps2_tx_err,
        input  ps2_rx_valid, ps2_rx_data, ps2_rx_err,
        output cmd_ready, cmd_done, cmd_status, init_done,
        output key_valid, key_data, key_err,
        output ps2_tx_req, ps2_tx_data
    );

    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, arg_byte,
        output ps2_tx_busy, ps2_tx_done, ps2_tx_err,
        output ps2_rx_valid, ps2_rx_data, ps2_rx_err,
        input  cmd_ready, cmd_done, cmd_status, init_done,
        input  key_valid, key_data, key_err,
        input  ps2_tx_req, ps2_tx_data
    );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS2 command sequencer: power-up keyboard reset (0xFF -> 0xFA -> 0xAA),
// user commands with an optional argument byte, resend/retry and reply timeout,
// and forwarding of unsolicited RX bytes to the key stream while idle.
module ps2_cmd_sequencer #(
    parameter int AUTO_INIT   = 1,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    ps2_cmd_sequencer_if.slave bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    // one spare bit so the width stays >= 1 even for MAX_RETRY = 0
    localparam int RT_W = $clog2(MAX_RETRY + 2);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    localparam logic [7:0] B_RESET  = 8'hFF;
    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_BAT_OK = 8'hAA;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_BAT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_ACK,
        WAIT_BAT,
        DONE
    } state_t;

    // With auto-init the machine wakes up already sending the 0xFF reset byte.
    localparam state_t RESET_STATE = (AUTO_INIT != 0) ? SEND : IDLE;

    state_t          state_q, state_d;
    logic [7:0]      cur_byte_q, cur_byte_d;
    logic [7:0]      arg_byte_q, arg_byte_d;
    logic            arg_pend_q, arg_pend_d;
    logic            init_run_q, init_run_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            cmd_done_q, cmd_done_d;
    logic [1:0]      cmd_status_q, cmd_status_d;
    logic            init_done_q, init_done_d;
    logic            key_valid_q, key_valid_d;
    logic [7:0]      key_data_q, key_data_d;
    logic            key_err_q, key_err_d;
    logic            tx_req_q, tx_req_d;
    logic [7:0]      tx_data_q, tx_data_d;

    // per-cycle decisions shared by several states
    logic            retry_req;
    logic            finish;
    logic [1:0]      fin_status;
    logic            rx_ack;
    logic            rx_bat_ok;
    logic            rx_any;

    assign rx_any    = bus.ps2_rx_valid | bus.ps2_rx_err;
    assign rx_ack    = bus.ps2_rx_valid & ~bus.ps2_rx_err & (bus.ps2_rx_data == B_ACK);
    assign rx_bat_ok = bus.ps2_rx_valid & ~bus.ps2_rx_err & (bus.ps2_rx_data == B_BAT_OK);

    // State register; the power-up state depends on whether init runs automatically
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured bytes, counters and registered outputs; a reset abandons any transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_byte_q   <= (AUTO_INIT != 0) ? B_RESET : 8'h00;
            arg_byte_q   <= 8'h00;
            arg_pend_q   <= 1'b0;
            init_run_q   <= (AUTO_INIT != 0);
            retry_q      <= '0;
            to_cnt_q     <= '0;
            cmd_done_q   <= 1'b0;
            cmd_status_q <= ST_OK;
            init_done_q  <= (AUTO_INIT == 0);
            key_valid_q  <= 1'b0;
            key_data_q   <= 8'h00;
            key_err_q    <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            cur_byte_q   <= cur_byte_d;
            arg_byte_q   <= arg_byte_d;
            arg_pend_q   <= arg_pend_d;
            init_run_q   <= init_run_d;
            retry_q      <= retry_d;
            to_cnt_q     <= to_cnt_d;
            cmd_done_q   <= cmd_done_d;
            cmd_status_q <= cmd_status_d;
            init_done_q  <= init_done_d;
            key_valid_q  <= key_valid_d;
            key_data_q   <= key_data_d;
            key_err_q    <= key_err_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Next-state and next-output logic; completion is flagged on entry to DONE
    always_comb begin
        state_d      = state_q;
        cur_byte_d   = cur_byte_q;
        arg_byte_d   = arg_byte_q;
        arg_pend_d   = arg_pend_q;
        init_run_d   = init_run_q;
        retry_d      = retry_q;
        to_cnt_d     = to_cnt_q;
        cmd_done_d   = 1'b0;
        cmd_status_d = cmd_status_q;
        init_done_d  = init_done_q;
        key_valid_d  = 1'b0;
        key_data_d   = key_data_q;
        key_err_d    = 1'b0;
        tx_req_d     = 1'b0;
        tx_data_d    = tx_data_q;
        retry_req    = 1'b0;
        finish       = 1'b0;
        fin_status   = ST_OK;

        case (state_q)
            IDLE: begin
                // unsolicited bytes are forwarded only here
                if (bus.ps2_rx_valid) begin
                    key_valid_d = 1'b1;
                    key_data_d  = bus.ps2_rx_data;
                end
                key_err_d = bus.ps2_rx_err;
                if (bus.cmd_valid) begin
                    cur_byte_d = bus.cmd_byte;
                    arg_byte_d = bus.arg_byte;
                    arg_pend_d = bus.cmd_has_arg;
                    retry_d    = '0;
                    init_run_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!bus.ps2_tx_busy) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = cur_byte_q;
                    state_d   = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // no timeout here: the PS2 core always ends a frame with done or err
                if (bus.ps2_tx_done) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_ACK;
                end else if (bus.ps2_tx_err) begin
                    retry_req = 1'b1;
                end
            end
            WAIT_ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rx_ack) begin
                    if (arg_pend_q) begin
                        cur_byte_d = arg_byte_q;
                        arg_pend_d = 1'b0;
                        retry_d    = '0;
                        state_d    = SEND;
                    end else if (cur_byte_q == B_RESET) begin
                        to_cnt_d = '0;
                        state_d  = WAIT_BAT;
                    end else begin
                        finish     = 1'b1;
                        fin_status = ST_OK;
                    end
                end else if (rx_any) begin
                    // 0xFE resend request, any unexpected byte, or a bad frame
                    retry_req = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    finish     = 1'b1;
                    fin_status = ST_TMO;
                end
            end
            WAIT_BAT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rx_bat_ok) begin
                    finish     = 1'b1;
                    fin_status = ST_OK;
                end else if (rx_any) begin
                    finish     = 1'b1;
                    fin_status = ST_BAT;
                end else if (to_cnt_q == TO_LAST) begin
                    finish     = 1'b1;
                    fin_status = ST_TMO;
                end
            end
            DONE: begin
                init_run_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // resend the same byte until MAX_RETRY resends have been used up
        if (retry_req) begin
            if (retry_q >= RT_MAX) begin
                finish     = 1'b1;
                fin_status = ST_NAK;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = SEND;
            end
        end

        if (finish) begin
            state_d      = DONE;
            cmd_done_d   = 1'b1;
            cmd_status_d = fin_status;
            if (init_run_q && (fin_status == ST_OK)) begin
                init_done_d = 1'b1;
            end
        end
    end

    // cmd_ready is forced low while reset is held so every output reads 0 then
    assign bus.cmd_ready   = (state_q == IDLE) && !reset;
    assign bus.cmd_done    = cmd_done_q;
    assign bus.cmd_status  = cmd_status_q;
    assign bus.init_done   = init_done_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_data    = key_data_q;
    assign bus.key_err     = key_err_q;
    assign bus.ps2_tx_req  = tx_req_q;
    assign bus.ps2_tx_data = tx_data_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: init, commands with argument, resend/NAK,
// transmit error, reply timeout, BAT failure, key forwarding and mid-transfer reset.
module tb_ps2_cmd_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ps2_cmd_sequencer_if bus();
    ps2_cmd_sequencer_if bus0();

    ps2_cmd_sequencer #(
        .AUTO_INIT   (1),
        .TIMEOUT_CYC (100),
        .MAX_RETRY   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ps2_cmd_sequencer #(
        .AUTO_INIT   (0),
        .TIMEOUT_CYC (100),
        .MAX_RETRY   (3)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int ncmp      = 0;
    int nfail     = 0;
    int cyc       = 0;
    int tx_cnt    = 0;
    int tx_seen   = 0;
    int done_cnt  = 0;
    int done_seen = 0;
    int key_cnt   = 0;
    int done_cyc  = 0;
    int txd_cyc   = 0;
    logic [7:0] last_tx     = 8'h00;
    logic [1:0] last_status = 2'b00;

    // event recorder: looks at the DUT just after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.ps2_tx_req === 1'b1) begin
            tx_cnt  = tx_cnt + 1;
            last_tx = bus.ps2_tx_data;
        end
        if (bus.ps2_tx_done === 1'b1) txd_cyc = cyc;
        if (bus.cmd_done === 1'b1) begin
            done_cnt    = done_cnt + 1;
            done_cyc    = cyc;
            last_status = bus.cmd_status;
        end
        if (bus.key_valid === 1'b1) key_cnt = key_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input logic [7:0] exp_b, input string tag);
        int n = 0;
        while (tx_cnt == tx_seen && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req"}, tx_cnt - tx_seen, 1);
        chk({tag, " byte"}, last_tx, exp_b);
        tx_seen = tx_cnt;
    endtask

    task automatic wait_done(input logic [1:0] exp_st, input string tag);
        int n = 0;
        while (done_cnt == done_seen && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, done_cnt - done_seen, 1);
        chk({tag, " status"}, last_status, exp_st);
        done_seen = done_cnt;
    endtask

    task automatic pulse_txdone();
        @(negedge clk);
        bus.ps2_tx_done = 1'b1;
        @(negedge clk);
        bus.ps2_tx_done = 1'b0;
    endtask

    task automatic pulse_txerr();
        @(negedge clk);
        bus.ps2_tx_err = 1'b1;
        @(negedge clk);
        bus.ps2_tx_err = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_rx_valid = 1'b1;
        bus.ps2_rx_data  = b;
        @(negedge clk);
        bus.ps2_rx_valid = 1'b0;
    endtask

    task automatic issue(input logic [7:0] c, input logic h, input logic [7:0] a);
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_byte    = c;
        bus.cmd_has_arg = h;
        bus.arg_byte    = a;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_byte     = 8'h00;
        bus.cmd_has_arg  = 1'b0;
        bus.arg_byte     = 8'h00;
        bus.ps2_tx_busy  = 1'b0;
        bus.ps2_tx_done  = 1'b0;
        bus.ps2_tx_err   = 1'b0;
        bus.ps2_rx_valid = 1'b0;
        bus.ps2_rx_data  = 8'h00;
        bus.ps2_rx_err   = 1'b0;
        bus0.cmd_valid    = 1'b0;
        bus0.cmd_byte     = 8'h00;
        bus0.cmd_has_arg  = 1'b0;
        bus0.arg_byte     = 8'h00;
        bus0.ps2_tx_busy  = 1'b0;
        bus0.ps2_tx_done  = 1'b0;
        bus0.ps2_tx_err   = 1'b0;
        bus0.ps2_rx_valid = 1'b0;
        bus0.ps2_rx_data  = 8'h00;
        bus0.ps2_rx_err   = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", bus.cmd_ready, 0);
        chk("rst init_done", bus.init_done, 0);
        chk("rst tx_req", bus.ps2_tx_req, 0);
        chk("rst cmd_done", bus.cmd_done, 0);
        chk("rst noinit init_done", bus0.init_done, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("noinit idle ready", bus0.cmd_ready, 1);
        chk("noinit no tx", bus0.ps2_tx_req, 0);

        // power-up init: FF, ACK, BAT ok
        wait_tx(8'hFF, "init");
        pulse_txdone();
        reply(8'hFA);
        chk("init no early done", done_cnt - done_seen, 0);
        reply(8'hAA);
        wait_done(2'b00, "init");
        chk("init_done set", bus.init_done, 1);
        chk("init no key", key_cnt, 0);
        @(negedge clk);
        chk("idle ready", bus.cmd_ready, 1);

        // command with argument, request held off while the core is busy
        bus.ps2_tx_busy = 1'b1;
        issue(8'hED, 1'b1, 8'h07);
        repeat (4) @(negedge clk);
        chk("busy holds req", tx_cnt - tx_seen, 0);
        bus.ps2_tx_busy = 1'b0;
        wait_tx(8'hED, "cmd ED");
        pulse_txdone();
        reply(8'hFA);
        wait_tx(8'h07, "arg 07");
        pulse_txdone();
        reply(8'hFA);
        wait_done(2'b00, "ED 07");
        chk("ack not forwarded", key_cnt, 0);

        // two resends then ACK
        issue(8'hF4, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_tx(8'hF4, "resend");
            pulse_txdone();
            reply(8'hFE);
        end
        wait_tx(8'hF4, "resend 3rd");
        pulse_txdone();
        reply(8'hFA);
        wait_done(2'b00, "resend ok");

        // four FE replies exhaust MAX_RETRY=3
        issue(8'hF4, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_tx(8'hF4, "nak");
            pulse_txdone();
            reply(8'hFE);
        end
        wait_done(2'b01, "nak");
        repeat (3) @(negedge clk);
        chk("nak no 5th send", tx_cnt - tx_seen, 0);

        // frame error on transmit is retried
        issue(8'hF5, 1'b0, 8'h00);
        wait_tx(8'hF5, "txerr first");
        pulse_txerr();
        wait_tx(8'hF5, "txerr resend");
        pulse_txdone();
        reply(8'hFA);
        wait_done(2'b00, "txerr");

        // no reply: timeout 100 cycles after the line ACK
        issue(8'hF4, 1'b0, 8'h00);
        wait_tx(8'hF4, "tmo");
        pulse_txdone();
        wait_done(2'b10, "tmo");
        chk("tmo cycles", done_cyc - txd_cyc, 100);

        // key forwarding in IDLE
        repeat (2) @(negedge clk);
        bus.ps2_rx_valid = 1'b1;
        bus.ps2_rx_data  = 8'h1C;
        @(negedge clk);
        bus.ps2_rx_valid = 1'b0;
        chk("key valid", bus.key_valid, 1);
        chk("key data", bus.key_data, 8'h1C);
        @(negedge clk);
        chk("key pulse end", bus.key_valid, 0);
        bus.ps2_rx_err = 1'b1;
        @(negedge clk);
        bus.ps2_rx_err = 1'b0;
        chk("key err", bus.key_err, 1);
        chk("key err no valid", bus.key_valid, 0);

        // rx byte and command accept in the same cycle
        @(negedge clk);
        bus.ps2_rx_valid = 1'b1;
        bus.ps2_rx_data  = 8'h1C;
        bus.cmd_valid    = 1'b1;
        bus.cmd_byte     = 8'hF4;
        bus.cmd_has_arg  = 1'b0;
        @(negedge clk);
        bus.ps2_rx_valid = 1'b0;
        bus.cmd_valid    = 1'b0;
        chk("same-cycle key", bus.key_valid, 1);
        chk("same-cycle data", bus.key_data, 8'h1C);
        chk("same-cycle started", bus.cmd_ready, 0);
        wait_tx(8'hF4, "same-cycle");
        pulse_txdone();
        reply(8'hFA);
        wait_done(2'b00, "same-cycle");
        chk("key count", key_cnt, 2);

        // reset while waiting for the ACK
        issue(8'hF4, 1'b0, 8'h00);
        wait_tx(8'hF4, "mid rst");
        pulse_txdone();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid rst cmd_ready", bus.cmd_ready, 0);
        chk("mid rst init_done", bus.init_done, 0);
        chk("mid rst tx_data", bus.ps2_tx_data, 0);
        chk("mid rst key_data", bus.key_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("mid rst no done", done_cnt - done_seen, 0);

        // init reruns after release; BAT failure code
        wait_tx(8'hFF, "reinit");
        pulse_txdone();
        reply(8'hFA);
        reply(8'hFC);
        wait_done(2'b11, "bat fail");
        chk("bat fail init_done", bus.init_done, 0);

        // user-issued FF goes through BAT but does not mark init done
        issue(8'hFF, 1'b0, 8'h00);
        wait_tx(8'hFF, "user FF");
        pulse_txdone();
        reply(8'hFA);
        reply(8'hAA);
        wait_done(2'b00, "user FF");
        chk("user FF init_done", bus.init_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
